// File: rtl/ser_link_scheduler.sv
// Round-robin scheduler and MSB-first serializer for the shared serial output link.
// Two word sources compete on valid/ready; one word is granted per frame, shifted out on a
// divided clock, and followed by GAP_BITS idle bit-times before the next decision.
module ser_link_scheduler #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic              clk_32,
  input  logic              rst_n_in,
  input  logic              req0_valid_in,
  input  logic [WORD_W-1:0] req0_data_in,
  output logic              req0_ready_out,
  input  logic              req1_valid_in,
  input  logic [WORD_W-1:0] req1_data_in,
  output logic              req1_ready_out,
  output logic              ser_out,
  output logic              ser_clk,
  output logic              ser_frame_out,
  output logic              busy_out,
  output logic              grant_out,
  output logic [15:0]       word_count_out
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
  localparam bit               NO_GAP   = (GAP_BITS == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_q, grant_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_clk_q, ser_clk_d;
  logic               frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               strobe;
  logic               decide;
  logic               any_valid;
  logic               sel;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shift_d      = shift_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    count_d      = count_q;

    strobe    = (div_cnt_q == DIV_LAST);
    any_valid = req0_valid_in | req1_valid_in;
    // Tie goes to the requester that did not own the previous frame
    sel       = (req0_valid_in & req1_valid_in) ? ~last_grant_q : ~req0_valid_in;
    decide    = strobe & ((state_q == ST_IDLE) |
                          ((state_q == ST_GAP) & (gap_cnt_q == GAP_LAST)) |
                          ((state_q == ST_SHIFT) & (bit_cnt_q == BIT_LAST) & NO_GAP));

    req0_ready_out = decide & ~sel & req0_valid_in;
    req1_ready_out = decide & sel & req1_valid_in;

    case (state_q)
      ST_SHIFT: begin
        if (strobe) begin
          shift_d   = {shift_q[WORD_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            count_d = count_q + CNT_W'(1);
            if (NO_GAP) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (strobe) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        end
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    // A grant overrides the end-of-frame / end-of-gap transition above
    if (decide && any_valid) begin
      shift_d      = sel ? req1_data_in : req0_data_in;
      bit_cnt_d    = '0;
      last_grant_d = sel;
      grant_d      = sel;
      state_d      = ST_SHIFT;
    end

    // Outputs follow the state of the bit period that starts at the next edge
    ser_out_d = (state_d == ST_SHIFT) & shift_d[WORD_W-1];
    ser_clk_d = (state_d == ST_SHIFT) & (div_cnt_d >= DIV_HALF);
    frame_d   = (state_d == ST_SHIFT);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_32 or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      count_q      <= '0;
      ser_out_q    <= 1'b0;
      ser_clk_q    <= 1'b0;
      frame_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      count_q      <= count_d;
      ser_out_q    <= ser_out_d;
      ser_clk_q    <= ser_clk_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
    end
  end

  assign ser_out        = ser_out_q;
  assign ser_clk        = ser_clk_q;
  assign ser_frame_out  = frame_q;
  assign busy_out       = busy_q;
  assign grant_out      = grant_q;
  assign word_count_out = count_q;

endmodule
